mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 64, address width.
- DATA_W, 32, data width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state changes on rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- if_req, in, 1, fetch read request.
- if_addr, in, ADDR_W, fetch byte address.
- if_gnt, out, 1, fetch request accepted this cycle.
- if_rvalid, out, 1, fetch read data valid.
- if_rdata, out, DATA_W, fetch read data.
- flush, in, 1, pipeline redirect; discard the fetch in flight.
- ls_req, in, 1, load/store request.
- ls_we, in, 1, 1 = store, 0 = load.
- ls_addr, in, ADDR_W, load/store byte address.
- ls_wdata, in, DATA_W, store data.
- ls_gnt, out, 1, load/store request accepted this cycle.
- ls_rvalid, out, 1, load data valid, or store acknowledge.
- ls_rdata, out, DATA_W, load data.
- mem_req, out, 1, memory request.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_gnt, in, 1, memory accepted the request.
- mem_rvalid, in, 1, memory response valid.
- mem_rdata, in, DATA_W, memory response data.

Function
REQ-003 The block SHALL share one memory port between the fetch (IF) and load/store (LS) requesters, with at most one transaction outstanding.
REQ-004 The FSM SHALL have two states, IDLE and WAIT, plus registers owner (IF/LS), drop (1 bit) and last (IF/LS).
REQ-005 In IDLE, mem_req SHALL combinationally equal (if_req & ~flush) | ls_req.
- mem_addr, mem_we and mem_wdata SHALL come from the winner.
- IF drives mem_we = 0 and mem_wdata = 0.
REQ-006 A handshake SHALL occur when mem_req & mem_gnt in IDLE.
- The winner's gnt SHALL be 1 in that same cycle and the loser's gnt 0.
- On the next edge the FSM SHALL move to WAIT and owner SHALL take the winner.
REQ-007 Without a handshake, the FSM SHALL stay in IDLE and both gnt outputs SHALL be 0.
REQ-008 Requesters SHALL hold req, addr, we and wdata stable until their gnt; the block does not check this.
REQ-009 In WAIT, mem_req and both gnt outputs SHALL be 0.
REQ-010 On mem_rvalid in WAIT:
- owner's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata in the same cycle (zero latency);
- the FSM SHALL return to IDLE on the next edge.
REQ-011 Back-to-back operation: a new request SHALL be grantable in the first IDLE cycle after the response, so the minimum period is 2 cycles per transaction.
REQ-012 if_rdata and ls_rdata SHALL be 0 whenever their rvalid is 0.
REQ-013 mem_rvalid in IDLE SHALL be ignored: no rvalid output and no state change.
REQ-014 Flush handling:
- In IDLE, flush SHALL block an IF grant in that cycle.
- If flush is asserted in WAIT with owner = IF, drop SHALL set.
- When drop is set, or flush is asserted in the response cycle, the IF response SHALL be consumed with if_rvalid = 0.
- drop SHALL clear on return to IDLE.
REQ-015 flush SHALL have no effect on LS transactions.
REQ-016 Default arbitration is fixed priority: LS wins over IF when both request.
REQ-017 last SHALL update to the winner at every handshake; it is used only under REQ-021.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously set state = IDLE, owner = IF, drop = 0 and last = IF.
REQ-019 During reset, all outputs SHALL be 0, including mem_req, regardless of the request inputs.
REQ-020 Reset in WAIT SHALL abandon the transaction; a later mem_rvalid SHALL be ignored per REQ-013.

Configuration
REQ-021 Macro MEM_ARB_RR_EN:
- Defined: round-robin arbitration. When both IF and LS request, the requester other than last SHALL win. After reset LS wins the first contest.
- Undefined: fixed priority per REQ-016; the last register MAY be optimized away.

Verification
REQ-022 Single fetch: if_req = 1, if_addr = 0x8, mem_gnt = 1 -> if_gnt = 1 the same cycle; mem_rvalid two cycles later with mem_rdata = 0x00108093 -> if_rvalid = 1, if_rdata = 0x00108093.
REQ-023 Contention, fixed priority: if_req = ls_req = 1 for 3 transactions, each with 1-cycle memory latency -> grant order LS, LS, LS; IF is granted only after ls_req drops.
REQ-024 Contention with MEM_ARB_RR_EN defined: both requesting continuously -> grant order LS, IF, LS, IF.
REQ-025 Store: ls_we = 1, ls_addr = 0x40, ls_wdata = 0xDEADBEEF -> mem_we = 1, mem_addr = 0x40, mem_wdata = 0xDEADBEEF; the ack gives ls_rvalid = 1.
REQ-026 Flush: IF granted, flush pulsed in WAIT, mem_rvalid = 1 two cycles later -> if_rvalid stays 0 and the FSM returns to IDLE; the next IF request is granted normally.
REQ-027 Reset mid-transaction: rst_n low in WAIT -> mem_req = 0 immediately; after release, a stray mem_rvalid produces no rvalid output.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   drop_q, drop_d;
  logic   if_cand;
  logic   ls_wins;
  logic   hs;

  // A flushed fetch is not a candidate for the port this cycle.
  assign if_cand = if_req & ~flush;

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  // On contention the requester that did not win most recently takes the port.
  assign ls_wins = ls_req & (~if_cand | (last_q == OWN_IF));

  always_comb begin
    last_d = last_q;
    if (hs) begin
      last_d = ls_wins ? OWN_LS : OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign ls_wins = ls_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
    end
  end

  // Next state and the zero-latency request/response steering.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    hs        = 1'b0;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_gnt    = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (ls_wins) begin
          mem_req   = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
        end else if (if_cand) begin
          mem_req   = 1'b1;
          mem_addr  = if_addr;
        end
        if (mem_req && mem_gnt) begin
          hs      = 1'b1;
          ls_gnt  = ls_wins;
          if_gnt  = ~ls_wins;
          state_d = ST_WAIT;
          owner_d = ls_wins ? OWN_LS : OWN_IF;
          drop_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (flush && (owner_q == OWN_IF)) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid) begin
          if (owner_q == OWN_LS) begin
            ls_rvalid = 1'b1;
            ls_rdata  = mem_rdata;
          end else if (!(drop_q || flush)) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, even with requests pending.
    if (!rst_n) begin
      hs        = 1'b0;
      if_gnt    = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_gnt    = 1'b0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    !(if_gnt && ls_gnt));
  a_rvalid_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    !(if_rvalid && ls_rvalid));
  a_wait_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_WAIT) |-> !(mem_req || if_gnt || ls_gnt));
  a_rdata_zero : assert property (@(posedge clk) disable iff (!rst_n)
    (!if_rvalid -> (if_rdata == '0)) && (!ls_rvalid -> (ls_rdata == '0)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one table row per clock cycle,
// followed by hand-written wait-state and asynchronous-reset sequences.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              flush;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .flush     (flush),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
  } vin_t;

  typedef struct packed {
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
  } vout_t;

  typedef struct {
    vin_t  i;
    vout_t o;
  } vec_t;

  vec_t  vecs[$];
  string names[$];
  int    n_vec;
  int    n_err;

  task automatic add(input string nm,
                     input logic rs, input logic ifr, input logic [63:0] ifa, input logic fl,
                     input logic lsr, input logic lwe, input logic [63:0] lsa, input logic [31:0] lwd,
                     input logic gnt, input logic rv, input logic [31:0] rd,
                     input logic eig, input logic eir, input logic [31:0] eird,
                     input logic elg, input logic elr, input logic [31:0] elrd,
                     input logic emr, input logic emw, input logic [63:0] ema, input logic [31:0] emd);
    vec_t v;
    v.i = '{rs, ifr, ifa, fl, lsr, lwe, lsa, lwd, gnt, rv, rd};
    v.o = '{eig, eir, eird, elg, elr, elrd, emr, emw, ema, emd};
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic drive(input vin_t i);
    rst_n      = i.rst_n;
    if_req     = i.if_req;
    if_addr    = i.if_addr;
    flush      = i.flush;
    ls_req     = i.ls_req;
    ls_we      = i.ls_we;
    ls_addr    = i.ls_addr;
    ls_wdata   = i.ls_wdata;
    mem_gnt    = i.mem_gnt;
    mem_rvalid = i.mem_rvalid;
    mem_rdata  = i.mem_rdata;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vin_t  idle_in;
    vout_t act;
    logic  ls_first;

    n_vec   = 0;
    n_err   = 0;
    idle_in = '0;
    drive(idle_in);

    //   name                rst ifr ifa     fl  lsr lwe lsa     lwd            gnt rv  rd              ig ir ird            lg lr lrd          mr mw ma      md
    add("reset_hold",         0, 1, 'h8,    0,  1,  1,  'h40,   'h1,           1,  1,  'h9,            0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("idle_quiet",         1, 0, 0,      0,  0,  0,  0,      0,             0,  0,  0,              0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("idle_stray_rvalid",  1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'h55,           0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("fetch_gnt",          1, 1, 'h8,    0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h8,    0);
    add("fetch_wait",         1, 0, 0,      0,  0,  0,  0,      0,             0,  0,  0,              0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("fetch_resp",         1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'h00108093,     0, 1, 'h00108093,    0, 0, 0,           0, 0, 0,      0);
    add("store_stall",        1, 0, 0,      0,  1,  1,  'h40,   'hDEADBEEF,    0,  0,  0,              0, 0, 0,             0, 0, 0,           1, 1, 'h40,   'hDEADBEEF);
    add("store_gnt",          1, 0, 0,      0,  1,  1,  'h40,   'hDEADBEEF,    1,  0,  0,              0, 0, 0,             1, 0, 0,           1, 1, 'h40,   'hDEADBEEF);
    add("store_ack",          1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'h1234,         0, 0, 0,             0, 1, 'h1234,      0, 0, 0,      0);
    add("load_b2b_gnt",       1, 0, 0,      0,  1,  0,  'h80,   0,             1,  0,  0,              0, 0, 0,             1, 0, 0,           1, 0, 'h80,   0);
    add("load_resp",          1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'hCAFE0001,     0, 0, 0,             0, 1, 'hCAFE0001,  0, 0, 0,      0);
    add("flush_if_gnt",       1, 1, 'h100,  0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h100,  0);
    add("flush_in_wait",      1, 0, 0,      1,  0,  0,  0,      0,             0,  0,  0,              0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("flush_dropped_resp", 1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'hBAD,          0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("refetch_gnt",        1, 1, 'h104,  0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h104,  0);
    add("refetch_resp",       1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'h1111,         0, 1, 'h1111,        0, 0, 0,           0, 0, 0,      0);
    add("flush_blocks_if",    1, 1, 'h108,  1,  0,  0,  0,      0,             1,  0,  0,              0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("flush_resp_gnt",     1, 1, 'h200,  0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h200,  0);
    add("flush_resp_cycle",   1, 0, 0,      1,  0,  0,  0,      0,             0,  1,  'h22,           0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("ls_flush_gnt",       1, 1, 'h10,   1,  1,  0,  'h300,  0,             1,  0,  0,              0, 0, 0,             1, 0, 0,           1, 0, 'h300,  0);
    add("ls_flush_resp",      1, 0, 0,      1,  0,  0,  0,      0,             0,  1,  'h33,           0, 0, 0,             0, 1, 'h33,        0, 0, 0,      0);
    add("reset_pre_contend",  0, 1, 'h10,   0,  1,  0,  'h20,   0,             1,  0,  0,              0, 0, 0,             0, 0, 0,           0, 0, 0,      0);

    // Both requesters hold their requests through four transactions.
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      ls_first = (k % 2) == 0;
`else
      ls_first = 1'b1;
`endif
      if (ls_first) begin
        add("contend_gnt_ls",   1, 1, 'h10, 0, 1, 0, 'h20, 0, 1, 0, 0,
            0, 0, 0, 1, 0, 0, 1, 0, 'h20, 0);
        add("contend_resp_ls",  1, 1, 'h10, 0, 1, 0, 'h20, 0, 0, 1, 32'hA0 + 32'(k),
            0, 0, 0, 0, 1, 32'hA0 + 32'(k), 0, 0, 0, 0);
      end else begin
        add("contend_gnt_if",   1, 1, 'h10, 0, 1, 0, 'h20, 0, 1, 0, 0,
            1, 0, 0, 0, 0, 0, 1, 0, 'h10, 0);
        add("contend_resp_if",  1, 1, 'h10, 0, 1, 0, 'h20, 0, 0, 1, 32'hA0 + 32'(k),
            0, 1, 32'hA0 + 32'(k), 0, 0, 0, 0, 0, 0, 0);
      end
    end

    //   name                rst ifr ifa     fl  lsr lwe lsa     lwd            gnt rv  rd              ig ir ird            lg lr lrd          mr mw ma      md
    add("if_after_ls_drops",  1, 1, 'h10,   0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h10,   0);
    add("if_after_ls_resp",   1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'hB0,           0, 1, 'hB0,          0, 0, 0,           0, 0, 0,      0);
    add("rst_mid_gnt",        1, 1, 'h400,  0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h400,  0);
    add("rst_in_wait",        0, 1, 'h400,  0,  1,  1,  'h44,   'h5,           1,  0,  0,              0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("stray_after_rst",    1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'h99,           0, 0, 0,             0, 0, 0,           0, 0, 0,      0);
    add("post_rst_gnt",       1, 1, 'h404,  0,  0,  0,  0,      0,             1,  0,  0,              1, 0, 0,             0, 0, 0,           1, 0, 'h404,  0);
    add("post_rst_resp",      1, 0, 0,      0,  0,  0,  0,      0,             0,  1,  'h7777,         0, 1, 'h7777,        0, 0, 0,           0, 0, 0,      0);

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].i);
      #1;
      act = '{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
              mem_req, mem_we, mem_addr, mem_wdata};
      n_vec++;
      if (act !== vecs[n].o) begin
        n_err++;
        $display("FAIL vec%0d %s: got ig=%b ir=%b ird=%h lg=%b lr=%b lrd=%h mr=%b mw=%b ma=%h md=%h | expected ig=%b ir=%b ird=%h lg=%b lr=%b lrd=%h mr=%b mw=%b ma=%h md=%h",
                 n, names[n],
                 act.if_gnt, act.if_rvalid, act.if_rdata, act.ls_gnt, act.ls_rvalid, act.ls_rdata,
                 act.mem_req, act.mem_we, act.mem_addr, act.mem_wdata,
                 vecs[n].o.if_gnt, vecs[n].o.if_rvalid, vecs[n].o.if_rdata, vecs[n].o.ls_gnt,
                 vecs[n].o.ls_rvalid, vecs[n].o.ls_rdata, vecs[n].o.mem_req, vecs[n].o.mem_we,
                 vecs[n].o.mem_addr, vecs[n].o.mem_wdata);
      end
    end

    // Memory stalls the grant for three cycles, then the response for two.
    @(negedge clk);
    drive(idle_in);
    rst_n   = 1'b1;
    if_req  = 1'b1;
    if_addr = 64'h500;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_mem_req", 64'(mem_req), 64'd1);
      chk("stall_no_gnt", 64'(if_gnt), 64'd0);
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    #1;
    chk("late_gnt", 64'(if_gnt), 64'd1);
    chk("late_gnt_addr", mem_addr, 64'h500);
    @(negedge clk);
    if_req  = 1'b0;
    if_addr = '0;
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("slow_resp_no_req", 64'(mem_req), 64'd0);
      chk("slow_resp_no_rvalid", 64'(if_rvalid), 64'd0);
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5A5A_0F0F;
    #1;
    chk("slow_resp_rvalid", 64'(if_rvalid), 64'd1);
    chk("slow_resp_rdata", 64'(if_rdata), 64'h5A5A_0F0F);

    // Reset asserted mid-cycle must silence a pending request at once.
    @(negedge clk);
    drive(idle_in);
    rst_n    = 1'b1;
    ls_req   = 1'b1;
    ls_addr  = 64'h600;
    #1;
    chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 64'(mem_req), 64'd0);
    chk("async_rst_mem_addr", mem_addr, 64'd0);

    // A short reset pulse between edges abandons the transaction in flight.
    @(negedge clk);
    rst_n   = 1'b1;
    mem_gnt = 1'b1;
    #1;
    chk("pulse_pre_gnt", 64'(ls_gnt), 64'd1);
    @(posedge clk);
    #2;
    ls_req  = 1'b0;
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    rst_n   = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_0BAD;
    #1;
    chk("pulse_stray_rvalid", 64'(ls_rvalid), 64'd0);
    chk("pulse_stray_rdata", 64'(ls_rdata), 64'd0);

    @(negedge clk);
    drive(idle_in);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
